// File: rtl/nt_node_test_sequencer.sv
// Built-in test sequencer for one Nt_Node subcircuit: reset hold, LFSR stimulus,
// CRC-16 output compaction and golden-signature compare.
module nt_node_test_sequencer #(
  parameter int N_IN       = 6,
  parameter int PIPE_DEPTH = 2,
  parameter int CLR_CYC    = 2
) (
  input  logic            I1470_clk,
  input  logic            I1477_rst,
  input  logic            start,
  input  logic            abort,
  input  logic [15:0]     seed,
  input  logic [15:0]     num_vectors,
  input  logic [15:0]     golden_sig,
  input  logic            dut_out,
  output logic [N_IN-1:0] stim,
  output logic            dut_rst,
  output logic            busy,
  output logic            done,
  output logic [15:0]     signature,
  output logic            mismatch,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_APPLY = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [15:0] CLR_LOAD   = 16'(CLR_CYC - 1);
  localparam logic [15:0] DRAIN_LOAD = 16'(PIPE_DEPTH - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [15:0]           r_cnt;
  logic [15:0]           w_cnt_next;
  logic [15:0]           r_lfsr;
  logic [15:0]           w_lfsr_next;
  logic [15:0]           r_nvec;
  logic [15:0]           w_nvec_next;
  logic [15:0]           r_sig;
  logic [15:0]           w_sig_next;
  logic                  r_mismatch;
  logic                  w_mismatch_next;
  logic [N_IN-1:0]       r_stim;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_dut_rst;
  logic [PIPE_DEPTH-1:0] r_cap_pipe;
  logic [PIPE_DEPTH-1:0] w_pipe_shift;
  logic                  w_cap_in;
  logic                  w_capture;
  logic                  w_launch;
  logic                  w_run_state;
  logic [15:0]           w_seed_eff;

  function automatic logic [15:0] f_lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] f_misr_step(input logic [15:0] s, input logic b);
    return {s[14:0], 1'b0} ^ ((s[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // start and abort are level inputs sampled on each rising edge; there is no
  // handshake back to the host other than busy/done. abort beats start.
  always_comb begin
    w_run_state  = (r_state == S_CLEAR) || (r_state == S_APPLY) || (r_state == S_DRAIN);
    w_launch     = ((r_state == S_IDLE) || (r_state == S_DONE)) && start && !abort;
    w_seed_eff   = (seed == 16'h0000) ? 16'h0001 : seed;
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_nvec_next  = r_nvec;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_launch) begin
          w_nvec_next = num_vectors;
          if (num_vectors == 16'h0000) begin
            w_next_state = S_DONE;
            w_cnt_next   = 16'h0000;
          end else begin
            w_next_state = S_CLEAR;
            w_cnt_next   = CLR_LOAD;
          end
        end
      end
      S_CLEAR: begin
        if (abort) begin
          w_next_state = S_IDLE;
          w_cnt_next   = 16'h0000;
        end else if (r_cnt == 16'h0000) begin
          w_next_state = S_APPLY;
          w_cnt_next   = r_nvec - 16'd1;
        end else begin
          w_cnt_next   = r_cnt - 16'd1;
        end
      end
      S_APPLY: begin
        // Counter holds vectors remaining after this one, so 0xFFFF never wraps.
        if (abort) begin
          w_next_state = S_IDLE;
          w_cnt_next   = 16'h0000;
        end else if (r_cnt == 16'h0000) begin
          w_next_state = S_DRAIN;
          w_cnt_next   = DRAIN_LOAD;
        end else begin
          w_cnt_next   = r_cnt - 16'd1;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          w_next_state = S_IDLE;
          w_cnt_next   = 16'h0000;
        end else if (r_cnt == 16'h0000) begin
          w_next_state = S_DONE;
          w_cnt_next   = 16'h0000;
        end else begin
          w_cnt_next   = r_cnt - 16'd1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_cnt_next   = 16'h0000;
      end
    endcase
  end

  // r_lfsr holds the vector currently on stim; it steps as each APPLY cycle ends.
  always_comb begin
    w_lfsr_next = r_lfsr;
    if (w_launch) begin
      w_lfsr_next = w_seed_eff;
    end else if (r_state == S_APPLY) begin
      w_lfsr_next = f_lfsr_step(r_lfsr);
    end
  end

  generate
    if (PIPE_DEPTH == 1) begin : g_pipe_one
      assign w_pipe_shift = w_cap_in;
    end else begin : g_pipe_multi
      assign w_pipe_shift = {r_cap_pipe[PIPE_DEPTH-2:0], w_cap_in};
    end
  endgenerate

  always_comb begin
    w_cap_in  = (r_state == S_APPLY) && !abort;
    w_capture = r_cap_pipe[PIPE_DEPTH-1];
    w_sig_next = r_sig;
    if (w_launch) begin
      w_sig_next = 16'h0000;
    end else if (w_capture) begin
      w_sig_next = f_misr_step(r_sig, dut_out);
    end
  end

  // The compare is taken once, on the edge that enters DONE, against the new signature.
  always_comb begin
    w_mismatch_next = r_mismatch;
    if (w_next_state != S_DONE) begin
      w_mismatch_next = 1'b0;
    end else if ((r_state != S_DONE) || w_launch) begin
      w_mismatch_next = (w_sig_next != golden_sig);
    end
  end

  always_ff @(posedge I1470_clk or posedge I1477_rst) begin
    if (I1477_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 16'h0000;
      r_lfsr     <= 16'h0000;
      r_nvec     <= 16'h0000;
      r_sig      <= 16'h0000;
      r_mismatch <= 1'b0;
      r_cap_pipe <= '0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_cnt_next;
      r_lfsr     <= w_lfsr_next;
      r_nvec     <= w_nvec_next;
      r_sig      <= w_sig_next;
      r_mismatch <= w_mismatch_next;
      if (w_run_state && abort) begin
        r_cap_pipe <= '0;
      end else begin
        r_cap_pipe <= w_pipe_shift;
      end
    end
  end

  always_ff @(posedge I1470_clk or posedge I1477_rst) begin
    if (I1477_rst) begin
      r_stim    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dut_rst <= 1'b1;
    end else begin
      r_stim    <= (w_next_state == S_APPLY) ? w_lfsr_next[N_IN-1:0] : '0;
      r_busy    <= (w_next_state == S_CLEAR) || (w_next_state == S_APPLY) ||
                   (w_next_state == S_DRAIN);
      r_done    <= (w_next_state == S_DONE);
      r_dut_rst <= !((w_next_state == S_APPLY) || (w_next_state == S_DRAIN));
    end
  end

  assign stim      = r_stim;
  assign dut_rst   = r_dut_rst;
  assign busy      = r_busy;
  assign done      = r_done;
  assign signature = r_sig;
  assign mismatch  = r_mismatch;
  assign dbg_state = r_state;

endmodule
